// File: rtl/cr_kme_kop_kdf_upsizer_pkg.sv
// Shared KDF key-path constants: word/beat widths and key-record framing.
package cr_kme_kop_kdf_upsizer_pkg;

    localparam int KDF_WORD_W          = 64;
    localparam int KDF_BEAT_W          = 2 * KDF_WORD_W;
    localparam int KDF_BEATS_PER_FRAME = 6;
    localparam int KDF_FIFO_DEPTH      = 3;
    localparam int KDF_KEY_RECORD_BYTES = KDF_BEATS_PER_FRAME * KDF_BEAT_W / 8;

    typedef struct packed {
        logic                  last;
        logic [KDF_BEAT_W-1:0] data;
    } kdf_beat_t;

endpackage

// File: rtl/cr_kme_kop_kdf_upsizer_if.sv
// Key-word input stream and 128-bit beat output stream of the KDF upsizer.
interface cr_kme_kop_kdf_upsizer_if;
    import cr_kme_kop_kdf_upsizer_pkg::*;

    logic [KDF_WORD_W-1:0] kdf_up_data;
    logic                  kdf_up_valid;
    logic                  kdf_up_last;
    logic                  up_kdf_stall;
    logic [KDF_BEAT_W-1:0] up_out_data;
    logic                  up_out_valid;
    logic                  up_out_last;
    logic                  up_out_ack;
    logic                  up_frame_err;

    modport slave (
        input  kdf_up_data, kdf_up_valid, kdf_up_last, up_out_ack,
        output up_kdf_stall, up_out_data, up_out_valid, up_out_last, up_frame_err
    );

    modport master (
        output kdf_up_data, kdf_up_valid, kdf_up_last, up_out_ack,
        input  up_kdf_stall, up_out_data, up_out_valid, up_out_last, up_frame_err
    );

endinterface

// File: rtl/cr_kme_kop_kdf_upsizer_fifo.sv
// Small circular FIFO; head read straight from storage, zero while empty.
module cr_kme_fifo #(
    parameter int DATA_SIZE  = 129,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] fifo_in,
    input  logic                 fifo_in_valid,
    output logic                 fifo_in_stall,
    input  logic                 fifo_in_stall_override,
    output logic [DATA_SIZE-1:0] fifo_out,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ack,
    output logic                 fifo_overflow,
    output logic                 fifo_underflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 full, empty, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);

    // Fullness is taken from the registered count, so a pop only frees a slot next cycle.
    assign fifo_in_stall  = full || fifo_in_stall_override;
    assign push           = fifo_in_valid && !fifo_in_stall;
    assign pop            = fifo_out_ack && !empty;
    assign fifo_overflow  = fifo_in_valid && fifo_in_stall;
    assign fifo_underflow = fifo_out_ack && empty;

    assign fifo_out_valid = !empty;
    assign fifo_out       = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fifo_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cr_kme_kop_kdf_upsizer.sv
// Packs 64-bit KDF key words into 128-bit beats, tags frame ends, flags bad framing.
module cr_kme_kop_kdf_upsizer
    import cr_kme_kop_kdf_upsizer_pkg::*;
#(
    parameter int BEATS_PER_FRAME = KDF_BEATS_PER_FRAME,
    parameter int FIFO_DEPTH      = KDF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cr_kme_kop_kdf_upsizer_if.slave   up_if
);

    localparam int CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_FRAME - 1);

    logic [KDF_WORD_W-1:0] hi_q, hi_d;
    logic                  half_full_q, half_full_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  frame_err_q, frame_err_d;

    logic      push_req, accept, push, fifo_stall;
    kdf_beat_t push_beat, head_beat;

    // A word that would not push never needs FIFO space, so it is never stalled.
    assign push_req           = half_full_q || up_if.kdf_up_last;
    assign up_if.up_kdf_stall = fifo_stall && push_req;
    assign accept             = up_if.kdf_up_valid && !up_if.up_kdf_stall;
    assign push               = accept && push_req;

    always_comb begin
        push_beat.last = up_if.kdf_up_last;
        push_beat.data = half_full_q ? {hi_q, up_if.kdf_up_data}
                                     : {up_if.kdf_up_data, {KDF_WORD_W{1'b0}}};
    end

    always_comb begin
        hi_d        = hi_q;
        half_full_d = half_full_q;
        beat_cnt_d  = beat_cnt_q;
        frame_err_d = 1'b0;
        if (accept) begin
            if (half_full_q) begin
                half_full_d = 1'b0;
            end else if (!up_if.kdf_up_last) begin
                hi_d        = up_if.kdf_up_data;
                half_full_d = 1'b1;
            end
        end
        if (push) begin
            beat_cnt_d  = (up_if.kdf_up_last || beat_cnt_q == CNT_LAST) ? '0 : beat_cnt_q + 1'b1;
            frame_err_d = up_if.kdf_up_last ? (beat_cnt_q != CNT_LAST) : (beat_cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q        <= '0;
            half_full_q <= 1'b0;
            beat_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            half_full_q <= half_full_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign up_if.up_frame_err = frame_err_q;

    cr_kme_fifo #(
        .DATA_SIZE  ($bits(kdf_beat_t)),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .fifo_in                (push_beat),
        .fifo_in_valid          (push),
        .fifo_in_stall          (fifo_stall),
        .fifo_in_stall_override (1'b0),
        .fifo_out               (head_beat),
        .fifo_out_valid         (up_if.up_out_valid),
        .fifo_out_ack           (up_if.up_out_ack),
        .fifo_overflow          (),
        .fifo_underflow         ()
    );

    assign up_if.up_out_data = head_beat.data;
    assign up_if.up_out_last = head_beat.last;

endmodule

// File: tb/tb_cr_kme_kop_kdf_upsizer.sv
// Directed bench for the KDF upsizer: framing, packing order, backpressure, reset.
module tb_cr_kme_kop_kdf_upsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [128:0] got_q [$];
    int           err_seen = 0;

    cr_kme_kop_kdf_upsizer_if ifc ();

    cr_kme_kop_kdf_upsizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up_if (ifc)
    );

    always #5 clk = ~clk;

    // Popped beats and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ifc.up_out_valid && ifc.up_out_ack)
            got_q.push_back({ifc.up_out_last, ifc.up_out_data});
        if (rst_n && ifc.up_frame_err)
            err_seen++;
    end

    task automatic do_reset();
        ifc.kdf_up_valid = 1'b0;
        ifc.kdf_up_last  = 1'b0;
        ifc.kdf_up_data  = '0;
        ifc.up_out_ack   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        err_seen = 0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        int n = 0;
        ifc.kdf_up_valid = 1'b1;
        ifc.kdf_up_data  = d;
        ifc.kdf_up_last  = l;
        @(negedge clk);
        while (ifc.up_kdf_stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ifc.up_kdf_stall) begin
            checks++; errors++;
            $display("FAIL send_word_timeout word=%h still stalled after %0d cycles", d, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        ifc.kdf_up_valid = 1'b0;
        ifc.kdf_up_last  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifc.kdf_up_valid = 1'b0;
        ifc.kdf_up_last  = 1'b0;
        ifc.kdf_up_data  = '0;
        ifc.up_out_ack   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifc.up_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifc.up_out_valid); end
        checks++; if (ifc.up_out_data !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", ifc.up_out_data); end
        checks++; if (ifc.up_out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", ifc.up_out_last); end
        checks++; if (ifc.up_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ifc.up_frame_err); end
        checks++; if (ifc.up_kdf_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", ifc.up_kdf_stall); end
        rst_n = 1'b1;
        got_q.delete();
        err_seen = 0;
    endtask

    task automatic test_full_frame();
        logic [128:0] exp, got;
        do_reset();
        ifc.up_out_ack = 1'b1;
        for (int i = 0; i < 12; i++) send_word(64'(i), i == 11);
        idle(6);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL full_frame_count got=%0d exp=6", got_q.size()); end
        for (int k = 0; k < 6; k++) begin
            exp = {k == 5, 64'(2 * k), 64'(2 * k + 1)};
            got = (k < got_q.size()) ? got_q[k] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL full_frame_beat%0d got=%h exp=%h", k, got, exp); end
        end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL full_frame_err got=%0d exp=0", err_seen); end
    endtask

    task automatic test_odd_last();
        logic [128:0] got;
        got_q.delete();
        err_seen = 0;
        send_word(64'hAA, 1'b0);
        send_word(64'hBB, 1'b0);
        send_word(64'hCC, 1'b1);
        idle(5);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL odd_count got=%0d exp=2", got_q.size()); end
        got = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (got !== {1'b0, 64'hAA, 64'hBB}) begin errors++; $display("FAIL odd_beat0 got=%h exp=%h", got, {1'b0, 64'hAA, 64'hBB}); end
        got = (got_q.size() > 1) ? got_q[1] : 'x;
        checks++; if (got !== {1'b1, 64'hCC, 64'h0}) begin errors++; $display("FAIL odd_beat1 got=%h exp=%h", got, {1'b1, 64'hCC, 64'h0}); end
        checks++; if (err_seen != 1) begin errors++; $display("FAIL odd_err_pulses got=%0d exp=1", err_seen); end
    endtask

    task automatic test_backpressure();
        logic [128:0] exp, got;
        do_reset();
        for (int i = 0; i < 6; i++) send_word(64'h10 + 64'(i), 1'b0);
        ifc.kdf_up_valid = 1'b1; ifc.kdf_up_data = 64'h16; ifc.kdf_up_last = 1'b0;
        #1;
        checks++; if (ifc.up_kdf_stall !== 1'b0) begin errors++; $display("FAIL bp_word7_stall got=%b exp=0", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        ifc.kdf_up_data = 64'h17;
        #1;
        checks++; if (ifc.up_kdf_stall !== 1'b1) begin errors++; $display("FAIL bp_word8_stall got=%b exp=1", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        checks++; if (ifc.up_kdf_stall !== 1'b1) begin errors++; $display("FAIL bp_word8_hold got=%b exp=1", ifc.up_kdf_stall); end
        checks++; if (ifc.up_out_data !== {64'h10, 64'h11}) begin errors++; $display("FAIL bp_head got=%h exp=%h", ifc.up_out_data, {64'h10, 64'h11}); end
        ifc.up_out_ack = 1'b1;
        #1;
        checks++; if (ifc.up_kdf_stall !== 1'b1) begin errors++; $display("FAIL bp_pop_cycle_stall got=%b exp=1", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        ifc.up_out_ack = 1'b0;
        #1;
        checks++; if (ifc.up_kdf_stall !== 1'b0) begin errors++; $display("FAIL bp_after_pop_stall got=%b exp=0", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        ifc.kdf_up_valid = 1'b0;
        ifc.up_out_ack   = 1'b1;
        idle(6);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            exp = {1'b0, 64'h10 + 64'(2 * k), 64'h11 + 64'(2 * k)};
            got = (k < got_q.size()) ? got_q[k] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", k, got, exp); end
        end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL bp_err got=%0d exp=0", err_seen); end
    endtask

    task automatic test_missing_last();
        logic [128:0] exp, got;
        do_reset();
        ifc.up_out_ack = 1'b1;
        for (int i = 0; i < 14; i++) send_word(64'h20 + 64'(i), 1'b0);
        // Beat 7 restarted the count, so five more beats close the frame cleanly.
        for (int i = 0; i < 10; i++) send_word(64'h30 + 64'(i), i == 9);
        idle(6);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL miss_count got=%0d exp=12", got_q.size()); end
        for (int k = 0; k < 12; k++) begin
            if (k < 7) exp = {1'b0, 64'h20 + 64'(2 * k), 64'h21 + 64'(2 * k)};
            else       exp = {k == 11, 64'h30 + 64'(2 * (k - 7)), 64'h31 + 64'(2 * (k - 7))};
            got = (k < got_q.size()) ? got_q[k] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL miss_beat%0d got=%h exp=%h", k, got, exp); end
        end
        checks++; if (err_seen != 1) begin errors++; $display("FAIL miss_err_pulses got=%0d exp=1", err_seen); end
    endtask

    task automatic test_reset_mid_frame();
        logic [128:0] exp, got;
        do_reset();
        for (int i = 0; i < 5; i++) send_word(64'hE0 + 64'(i), 1'b0);
        ifc.kdf_up_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (ifc.up_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", ifc.up_out_valid); end
        checks++; if (ifc.up_out_data !== 128'h0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", ifc.up_out_data); end
        checks++; if (ifc.up_out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last got=%b exp=0", ifc.up_out_last); end
        checks++; if (ifc.up_kdf_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%b exp=0", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        err_seen = 0;
        ifc.up_out_ack = 1'b1;
        for (int i = 0; i < 12; i++) send_word(64'h40 + 64'(i), i == 11);
        idle(6);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL mid_count got=%0d exp=6", got_q.size()); end
        for (int k = 0; k < 6; k++) begin
            exp = {k == 5, 64'h40 + 64'(2 * k), 64'h41 + 64'(2 * k)};
            got = (k < got_q.size()) ? got_q[k] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL mid_beat%0d got=%h exp=%h", k, got, exp); end
        end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL mid_err got=%0d exp=0", err_seen); end
    endtask

    task automatic test_push_pop();
        logic [128:0] got;
        do_reset();
        send_word(64'h50, 1'b0);
        send_word(64'h51, 1'b0);
        send_word(64'h52, 1'b0);
        ifc.kdf_up_data = 64'h53;
        ifc.up_out_ack  = 1'b1;
        #1;
        checks++; if (ifc.up_kdf_stall !== 1'b0) begin errors++; $display("FAIL pp_stall got=%b exp=0", ifc.up_kdf_stall); end
        @(posedge clk); #1;
        ifc.kdf_up_valid = 1'b0;
        ifc.up_out_ack   = 1'b0;
        @(posedge clk); #1;
        checks++; if (ifc.up_out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid got=%b exp=1", ifc.up_out_valid); end
        checks++; if (ifc.up_out_data !== {64'h52, 64'h53}) begin errors++; $display("FAIL pp_head got=%h exp=%h", ifc.up_out_data, {64'h52, 64'h53}); end
        ifc.up_out_ack = 1'b1;
        idle(3);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL pp_count got=%0d exp=2", got_q.size()); end
        got = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (got !== {1'b0, 64'h50, 64'h51}) begin errors++; $display("FAIL pp_beat0 got=%h exp=%h", got, {1'b0, 64'h50, 64'h51}); end
        got = (got_q.size() > 1) ? got_q[1] : 'x;
        checks++; if (got !== {1'b0, 64'h52, 64'h53}) begin errors++; $display("FAIL pp_beat1 got=%h exp=%h", got, {1'b0, 64'h52, 64'h53}); end
        checks++; if (ifc.up_out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%b exp=0", ifc.up_out_valid); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_odd_last();
        test_backpressure();
        test_missing_last();
        test_reset_mid_frame();
        test_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
